// File: rtl/multihat_pkg.sv
// Shared definitions for the multi-input hat adder tree.
//   hat_mode_t        : per-sample combine mode (average per level / saturating sum)
//   HAT_WIDTH_DEFAULT : default sample width
//   sat_to_width      : clip a wide signed value into a narrower signed range
package multihat_pkg;

  typedef enum logic {
    MODE_AVG = 1'b0,
    MODE_SUM = 1'b1
  } hat_mode_t;

  localparam int HAT_WIDTH_DEFAULT = 16;

  // Widest internal value the saturate helper accepts.
  localparam int SAT_BITS = 72;

  // Saturate a sign-extended value into a signed field of 'width' bits.
  // The result stays in SAT_BITS; callers keep the low 'width' bits.
  function automatic logic signed [SAT_BITS-1:0] sat_to_width(
    input  logic signed [SAT_BITS-1:0] value,
    input  int unsigned                width,
    output logic                       clipped
  );
    logic signed [SAT_BITS-1:0] hi;
    logic signed [SAT_BITS-1:0] lo;
    hi = (72'sd1 <<< (width - 1)) - 72'sd1;
    lo = -(72'sd1 <<< (width - 1));
    clipped = 1'b0;
    sat_to_width = value;
    if (value > hi) begin
      sat_to_width = hi;
      clipped      = 1'b1;
    end else if (value < lo) begin
      sat_to_width = lo;
      clipped      = 1'b1;
    end
  endfunction

endpackage

// File: rtl/multihat_tree_stage.sv
// One level of the hat adder tree: N_NODES/2 pairwise adders followed by
// a register, plus the valid and mode bits that travel with the sample.
//   clk, reset_n : clock, synchronous active-low reset
//   en           : advance; 0 holds every register of this level
//   in_valid/in_mode/in_data  : incoming level, N_NODES values of IW bits
//   out_valid/out_mode/out_data : registered level, N_NODES/2 values of IW bits
module multihat_tree_stage
  import multihat_pkg::*;
#(
  parameter int N_NODES = 2,
  parameter int IW      = 17
) (
  input  logic                       clk,
  input  logic                       reset_n,
  input  logic                       en,
  input  logic                       in_valid,
  input  logic                       in_mode,
  input  logic [N_NODES*IW-1:0]      in_data,
  output logic                       out_valid,
  output logic                       out_mode,
  output logic [(N_NODES/2)*IW-1:0]  out_data
);

  localparam int N_OUT = N_NODES / 2;

  logic [N_OUT*IW-1:0] data_next;
  logic [N_OUT*IW-1:0] data_reg;
  logic                valid_reg;
  logic                mode_reg;

  genvar gi;
  generate
    for (gi = 0; gi < N_OUT; gi++) begin : g_node
      logic [IW-1:0] a;
      logic [IW-1:0] b;
      logic [IW:0]   sum;
      assign a   = in_data[(2*gi)*IW +: IW];
      assign b   = in_data[(2*gi+1)*IW +: IW];
      // One guard bit so the pair sum is exact before the optional halving.
      assign sum = {a[IW-1], a} + {b[IW-1], b};
      // Dropping the LSB of the exact sum is an arithmetic shift (floor).
      assign data_next[gi*IW +: IW] =
        (hat_mode_t'(in_mode) == MODE_SUM) ? sum[IW-1:0] : sum[IW:1];
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      valid_reg <= 1'b0;
      mode_reg  <= 1'b0;
      data_reg  <= '0;
    end else if (en) begin
      valid_reg <= in_valid;
      mode_reg  <= in_mode;
      data_reg  <= data_next;
    end
  end

  assign out_valid = valid_reg;
  assign out_mode  = mode_reg;
  assign out_data  = data_reg;

endmodule

// File: rtl/multihat_adder_tree.sv
// Fully pipelined signed adder tree combining NUM_IN uniform samples into one
// approximately Gaussian "hat" sample. Latency is LEVELS enabled cycles.
//   clk, reset_n : clock, synchronous active-low reset (wins over en)
//   en           : pipeline advance; 0 freezes every stage including outputs
//   in_valid     : in_data holds a sample set
//   in_mode      : 0 = average at every level, 1 = saturating full sum
//   in_data      : NUM_IN packed signed inputs, input k at [k*WIDTH +: WIDTH]
//   out_valid    : out_data holds a result
//   out_data     : signed result
//   out_sat      : sum-mode result was clipped (never set in average mode)
module multihat_adder_tree
  import multihat_pkg::*;
#(
  parameter int WIDTH  = HAT_WIDTH_DEFAULT,
  parameter int NUM_IN = 8
) (
  input  logic                    clk,
  input  logic                    reset_n,
  input  logic                    en,
  input  logic                    in_valid,
  input  logic                    in_mode,
  input  logic [NUM_IN*WIDTH-1:0] in_data,
  output logic                    out_valid,
  output logic [WIDTH-1:0]        out_data,
  output logic                    out_sat
);

  localparam int LEVELS = $clog2(NUM_IN);
  // Growth room for a full sum at every level: the root never overflows.
  localparam int IW     = WIDTH + LEVELS;

  generate
    if (NUM_IN < 2 || NUM_IN > 64 || (NUM_IN & (NUM_IN - 1)) != 0) begin : g_bad_num_in
      $error("multihat_adder_tree: NUM_IN must be a power of two in 2..64");
    end
    if (IW > SAT_BITS) begin : g_bad_width
      $error("multihat_adder_tree: WIDTH too large for the saturate helper");
    end
  endgenerate

  // All tree levels packed into one triangular bus: level l holds NUM_IN>>l
  // nodes starting at node offset 2*NUM_IN - 2*(NUM_IN>>l); the root is last.
  logic [(2*NUM_IN-1)*IW-1:0] tree;
  logic [LEVELS:0]            vld;
  logic [LEVELS:0]            mode;

  assign vld[0]  = in_valid;
  assign mode[0] = in_mode;

  genvar gi;
  generate
    for (gi = 0; gi < NUM_IN; gi++) begin : g_ext
      assign tree[gi*IW +: IW] =
        {{LEVELS{in_data[gi*WIDTH + WIDTH - 1]}}, in_data[gi*WIDTH +: WIDTH]};
    end

    for (gi = 0; gi < LEVELS; gi++) begin : g_level
      localparam int N_NODES  = NUM_IN >> gi;
      localparam int BASE_IN  = (2*NUM_IN - 2*N_NODES) * IW;
      localparam int BASE_OUT = (2*NUM_IN - N_NODES) * IW;
      multihat_tree_stage #(
        .N_NODES (N_NODES),
        .IW      (IW)
      ) u_stage (
        .clk       (clk),
        .reset_n   (reset_n),
        .en        (en),
        .in_valid  (vld[gi]),
        .in_mode   (mode[gi]),
        .in_data   (tree[BASE_IN +: N_NODES*IW]),
        .out_valid (vld[gi+1]),
        .out_mode  (mode[gi+1]),
        .out_data  (tree[BASE_OUT +: (N_NODES/2)*IW])
      );
    end
  endgenerate

  logic [IW-1:0]              root;
  logic signed [SAT_BITS-1:0] sat_in;
  logic signed [SAT_BITS-1:0] sat_val;
  logic                       clipped;

  assign root   = tree[(2*NUM_IN-2)*IW +: IW];
  assign sat_in = {{(SAT_BITS-IW){root[IW-1]}}, root};

  // The output is taken straight from the last stage register; only the
  // clip/truncate logic sits between it and the ports.
  always_comb begin
    clipped  = 1'b0;
    sat_val  = sat_to_width(sat_in, WIDTH, clipped);
    out_data = root[WIDTH-1:0];
    out_sat  = 1'b0;
    if (hat_mode_t'(mode[LEVELS]) == MODE_SUM) begin
      out_data = sat_val[WIDTH-1:0];
      out_sat  = clipped;
    end
  end

  assign out_valid = vld[LEVELS];

endmodule
